// File: rtl/exception_vector_unit.sv
// Exception sequencer: latches requests, resolves them by fixed priority, captures EPC,
// fetches the handler byte from the vector table and issues a one-cycle PC write.
module exception_vector_unit #(
  parameter int NUM_EXC  = 3,
  parameter int VEC_BASE = 253,
  parameter int MEM_LAT  = 1,
  parameter int CW       = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_EXC-1:0] i_exc_req,
  input  logic [31:0]        i_pc_in,
  input  logic [7:0]         i_mem_data,
  output logic               o_busy,
  output logic               o_mem_rd,
  output logic [31:0]        o_mem_addr,
  output logic [31:0]        o_epc_out,
  output logic               o_epc_we,
  output logic [31:0]        o_pc_out,
  output logic               o_pc_we,
  output logic [CW-1:0]      o_cause
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [31:0] VEC_BASE_W = 32'(VEC_BASE);
  localparam logic [1:0]  LAT_M1     = 2'(MEM_LAT - 1);

  state_t             r_state;
  logic [NUM_EXC-1:0] r_pending;
  logic [1:0]         r_cnt;
  logic               r_busy;
  logic               r_mem_rd;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_epc;
  logic               r_epc_we;
  logic               r_pc_we;
  logic [CW-1:0]      r_cause;

  logic [NUM_EXC-1:0] w_cand;
  logic [NUM_EXC-1:0] w_onehot;
  logic [NUM_EXC-1:0] w_served;
  logic [CW-1:0]      w_idx;
  logic               w_start;

  assign w_cand = r_pending | i_exc_req;

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    w_idx    = '0;
    w_onehot = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      w_idx    = w_cand[i] ? CW'(i) : w_idx;
      w_onehot = w_cand[i] ? (NUM_EXC'(1) << i) : w_onehot;
    end
  end

  assign w_start  = (r_state == S_IDLE) && (|w_cand);
  assign w_served = w_start ? w_onehot : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_cand & ~w_served;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_busy     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= 32'd0;
      r_epc      <= 32'd0;
      r_epc_we   <= 1'b0;
      r_pc_we    <= 1'b0;
      r_cause    <= '0;
    end else begin
      r_epc_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_FETCH;
            r_busy     <= 1'b1;
            r_mem_rd   <= 1'b1;
            r_epc_we   <= 1'b1;
            r_epc      <= i_pc_in - 32'd4;
            r_cause    <= w_idx;
            r_mem_addr <= VEC_BASE_W + {{(32 - CW){1'b0}}, w_idx};
            r_cnt      <= LAT_M1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (r_cnt == 2'd0) begin
            r_state  <= S_WRITE;
            r_mem_rd <= 1'b0;
            r_pc_we  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_pc_we <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_mem_rd <= 1'b0;
          r_pc_we  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_mem_rd   = r_mem_rd;
  assign o_mem_addr = r_mem_addr;
  assign o_epc_out  = r_epc;
  assign o_epc_we   = r_epc_we;
  assign o_pc_we    = r_pc_we;
  assign o_cause    = r_cause;
  // Handler byte is passed straight through while the PC write is active.
  assign o_pc_out   = r_pc_we ? {24'd0, i_mem_data} : 32'd0;

endmodule

// File: tb/tb_exception_vector_unit.sv
// Bench for exception_vector_unit: a default build and a 5-source / 3-cycle-latency build
// driven side by side, checked against a service-timeline reference model.
module tb_exception_vector_unit;

  localparam int L0 = 1;
  localparam int VB0 = 253;
  localparam int L1 = 3;
  localparam int VB1 = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req0;
  logic [4:0]  req1;
  logic [31:0] pc_in;
  logic [7:0]  mem_data0, mem_data1;
  logic        busy0, mem_rd0, epc_we0, pc_we0;
  logic        busy1, mem_rd1, epc_we1, pc_we1;
  logic [31:0] mem_addr0, epc_out0, pc_out0;
  logic [31:0] mem_addr1, epc_out1, pc_out1;
  logic [1:0]  cause0;
  logic [2:0]  cause1;

  always #5 clk = ~clk;

  exception_vector_unit #(.NUM_EXC(3), .VEC_BASE(VB0), .MEM_LAT(L0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_exc_req(req0), .i_pc_in(pc_in), .i_mem_data(mem_data0),
    .o_busy(busy0), .o_mem_rd(mem_rd0), .o_mem_addr(mem_addr0), .o_epc_out(epc_out0),
    .o_epc_we(epc_we0), .o_pc_out(pc_out0), .o_pc_we(pc_we0), .o_cause(cause0)
  );

  exception_vector_unit #(.NUM_EXC(5), .VEC_BASE(VB1), .MEM_LAT(L1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_exc_req(req1), .i_pc_in(pc_in), .i_mem_data(mem_data1),
    .o_busy(busy1), .o_mem_rd(mem_rd1), .o_mem_addr(mem_addr1), .o_epc_out(epc_out1),
    .o_epc_we(epc_we1), .o_pc_out(pc_out1), .o_pc_we(pc_we1), .o_cause(cause1)
  );

  // Vector-table memory with a read pipeline of the configured latency per build.
  logic [7:0] mem [256];
  logic [3:0] rv0 = 4'd0;
  logic [3:0] rv1 = 4'd0;
  logic [7:0] ra0 [4];
  logic [7:0] ra1 [4];

  always @(posedge clk) begin
    rv0    <= {rv0[2:0], mem_rd0};
    rv1    <= {rv1[2:0], mem_rd1};
    ra0[0] <= mem_addr0[7:0];
    ra1[0] <= mem_addr1[7:0];
    for (int i = 3; i > 0; i--) begin
      ra0[i] <= ra0[i-1];
      ra1[i] <= ra1[i-1];
    end
  end

  assign mem_data0 = rv0[L0-1] ? mem[ra0[L0-1]] : ~mem[mem_addr0[7:0]];
  assign mem_data1 = rv1[L1-1] ? mem[ra1[L1-1]] : ~mem[mem_addr1[7:0]];

  typedef struct packed {
    logic        busy;
    logic        rd;
    logic        ewe;
    logic        pwe;
    logic [31:0] addr;
    logic [31:0] epc;
    logic [31:0] pco;
    logic [2:0]  cause;
  } obs_t;

  obs_t obs [2];
  assign obs[0] = {busy0, mem_rd0, epc_we0, pc_we0, mem_addr0, epc_out0, pc_out0, 1'b0, cause0};
  assign obs[1] = {busy1, mem_rd1, epc_we1, pc_we1, mem_addr1, epc_out1, pc_out1, cause1};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: pending set plus the edge at which the current service started.
  logic [4:0]  m_pend  [2];
  int          m_start [2];
  int          m_nxt   [2];
  logic [31:0] m_epc   [2];
  logic [31:0] m_addr  [2];
  logic [2:0]  m_cause [2];

  function automatic int lat(input int d);
    return (d == 0) ? L0 : L1;
  endfunction

  function automatic int vb(input int d);
    return (d == 0) ? VB0 : VB1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d]  = 5'd0;
      m_start[d] = -100;
      m_nxt[d]   = cyc + 1;
      m_epc[d]   = 32'd0;
      m_addr[d]  = 32'd0;
      m_cause[d] = 3'd0;
    end
  endtask

  task automatic model_edge(input int d, input logic [4:0] r);
    logic [4:0] cand;
    cand = m_pend[d] | r;
    if (cyc >= m_nxt[d] && cand != 5'd0) begin
      for (int i = 0; i < 5; i++) begin
        if (cand[i]) begin
          m_start[d] = cyc;
          m_nxt[d]   = cyc + lat(d) + 2;
          m_epc[d]   = pc_in - 32'd4;
          m_cause[d] = 3'(i);
          m_addr[d]  = 32'(vb(d) + i);
          cand[i]    = 1'b0;
          break;
        end
      end
    end
    m_pend[d] = cand;
  endtask

  task automatic check_all(input int d);
    logic f, w;
    f = (cyc >= m_start[d]) && (cyc < m_start[d] + lat(d));
    w = (cyc == m_start[d] + lat(d));
    check_eq($sformatf("d%0d busy", d), 32'(obs[d].busy), 32'(f | w));
    check_eq($sformatf("d%0d mem_rd", d), 32'(obs[d].rd), 32'(f));
    check_eq($sformatf("d%0d epc_we", d), 32'(obs[d].ewe), 32'(cyc == m_start[d]));
    check_eq($sformatf("d%0d pc_we", d), 32'(obs[d].pwe), 32'(w));
    check_eq($sformatf("d%0d pc_out", d), obs[d].pco, w ? {24'd0, mem[m_addr[d][7:0]]} : 32'd0);
    check_eq($sformatf("d%0d mem_addr", d), obs[d].addr, m_addr[d]);
    check_eq($sformatf("d%0d epc_out", d), obs[d].epc, m_epc[d]);
    check_eq($sformatf("d%0d cause", d), 32'(obs[d].cause), 32'(m_cause[d]));
  endtask

  task automatic step(input logic [2:0] r0, input logic [4:0] r1, input logic [31:0] pc);
    req0  = r0;
    req1  = r1;
    pc_in = pc;
    @(posedge clk);
    cyc++;
    model_edge(0, {2'b00, r0});
    model_edge(1, r1);
    @(negedge clk);
    check_all(0);
    check_all(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all(0);
    check_all(1);
    @(posedge clk);
    @(negedge clk);
    check_all(0);
    check_all(1);
    rst = 1'b0;
  endtask

  initial begin
    int pw;
    logic [2:0]  r0;
    logic [4:0]  r1;
    logic [31:0] pc;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[254] = 8'h80;
    mem[253] = 8'h10;
    mem[255] = 8'h20;
    mem[204] = 8'h5A;
    req0  = 3'd0;
    req1  = 5'd0;
    pc_in = 32'd0;
    do_reset();

    // Single request on source 1, and the top source on the wide build.
    step(3'b010, 5'b10000, 32'h0000_0040);
    check_eq("s1 fetch mem_addr", mem_addr0, 32'd254);
    check_eq("s1 fetch mem_rd", 32'(mem_rd0), 32'd1);
    check_eq("s1 fetch epc_we", 32'(epc_we0), 32'd1);
    check_eq("s1 fetch epc_out", epc_out0, 32'h0000_003C);
    check_eq("w5 mem_addr", mem_addr1, 32'd204);
    check_eq("w5 cause", 32'(cause1), 32'd4);
    step(3'b000, 5'b00000, 32'h1234_5678);
    check_eq("s1 write pc_we", 32'(pc_we0), 32'd1);
    check_eq("s1 write pc_out", pc_out0, 32'h0000_0080);
    check_eq("s1 write cause", 32'(cause0), 32'd1);
    step(3'b000, 5'b00000, 32'h0);
    check_eq("s1 idle busy", 32'(busy0), 32'd0);
    step(3'b000, 5'b00000, 32'h0);
    check_eq("lat3 pc_we 4th cycle", 32'(pc_we1), 32'd1);
    check_eq("lat3 pc_out", pc_out1, 32'h0000_005A);
    step(3'b000, 5'b00000, 32'h0);

    // Two simultaneous requests, with pc_in wrapping below zero.
    step(3'b101, 5'b00000, 32'h0000_0000);
    check_eq("s2 first cause", 32'(cause0), 32'd0);
    check_eq("s2 epc wrap", epc_out0, 32'hFFFF_FFFC);
    step(3'b000, 5'b00000, 32'h0);
    check_eq("s2 first pc_out", pc_out0, 32'h0000_0010);
    step(3'b000, 5'b00000, 32'h0);
    check_eq("s2 gap busy", 32'(busy0), 32'd0);
    step(3'b000, 5'b00000, 32'h0);
    check_eq("s2 second cause", 32'(cause0), 32'd2);
    check_eq("s2 second mem_addr", mem_addr0, 32'd255);
    step(3'b000, 5'b00000, 32'h0);
    check_eq("s2 second pc_out", pc_out0, 32'h0000_0020);
    step(3'b000, 5'b00000, 32'h0);

    // Reset during FETCH with another source pending: nothing may follow.
    step(3'b011, 5'b00000, 32'h0000_1000);
    do_reset();
    pw = 0;
    for (int k = 0; k < 6; k++) begin
      step(3'b000, 5'b00000, 32'h0);
      pw += 32'(pc_we0);
    end
    check_eq("no pc_we after reset", 32'(pw), 32'd0);

    for (int k = 0; k < 600; k++) begin
      r0 = 3'($urandom) & 3'($urandom) & 3'($urandom);
      r1 = 5'($urandom) & 5'($urandom) & 5'($urandom);
      pc = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(r0, r1, pc);
      end
    end
    for (int k = 0; k < 20; k++) step(3'b000, 5'b00000, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exception_vector_unit.md
Name: exception_vector_unit

Overview:
- Parametrised exception sequencer for the multicycle datapath; successor to the fixed three-entry exception-to-vector-address mapping.
- Latches exception requests and resolves them by fixed priority.
- Captures EPC, reads the handler byte from the vector table in memory, and issues a one-cycle PC write.
- Sits beside the main control FSM, which stalls while busy is high.

Parameters:
- NUM_EXC, 3, number of exception sources; index 0 has the highest priority.
- VEC_BASE, 253, byte address of the vector-table entry for exception 0; entry i is at VEC_BASE+i.
- MEM_LAT, 1, read latency in cycles from mem_rd/mem_addr to valid mem_data (range 1..4).
- CW, $clog2(NUM_EXC) (minimum 1), width of the cause field.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- exc_req  input  NUM_EXC  per-source exception request, level or pulse, sampled each rising edge.
- pc_in  input  32  PC of the instruction after the faulting one (already incremented by 4).
- mem_data  input  8  vector byte returned by memory.
- busy  output  1  high while an exception is being serviced.
- mem_rd  output  1  memory read strobe.
- mem_addr  output  32  vector-table read address.
- epc_out  output  32  captured EPC value.
- epc_we  output  1  one-cycle EPC register write enable.
- pc_out  output  32  handler address, zero-extended mem_data.
- pc_we  output  1  one-cycle PC write enable.
- cause  output  CW  index of the exception most recently serviced.

Behaviour:
- Reset:
  - State goes to IDLE; pending=0, busy=0, mem_rd=0, mem_addr=0, epc_out=0, epc_we=0, pc_out=0, pc_we=0, cause=0.
  - Reset asserted mid-service aborts the service: no pc_we pulse follows, and the pending request is lost.
- Pending register (NUM_EXC bits):
  - Each edge: pending <= (pending | exc_req) & ~served, where served is the one-hot index taken this edge.
  - Requests arriving while busy are kept and serviced afterwards; they are never dropped.
  - A request that is already pending and arrives again merges into the same bit and is serviced once.
- States: IDLE, FETCH, WRITE.
- IDLE:
  - Candidate set is pending | exc_req.
  - If the set is non-zero:
    - Select the lowest set index i.
    - Register epc_out <= pc_in - 4 (mod 2^32, so pc_in=0 gives 0xFFFFFFFC).
    - Register cause <= i and mem_addr <= VEC_BASE + i.
    - Load the latency counter with MEM_LAT-1 and go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - busy=1, mem_rd=1, mem_addr held stable.
  - epc_we=1 in the first FETCH cycle only.
  - Counter decrements each cycle; when it is 0, go to WRITE next edge. FETCH lasts exactly MEM_LAT cycles.
- WRITE (one cycle):
  - busy=1, mem_rd=0, pc_we=1, pc_out = {24'b0, mem_data}, sampled combinationally this cycle.
  - Next edge goes to IDLE. pc_out returns to 0 and pc_we to 0 outside WRITE.
- Latency: exc_req seen at edge E0 gives FETCH in cycles 1..MEM_LAT, WRITE in cycle MEM_LAT+1, IDLE in cycle MEM_LAT+2. The next pending exception can enter FETCH in cycle MEM_LAT+3.
- Back-to-back:
  - The IDLE cycle between services is mandatory.
  - A request arriving in the same cycle as WRITE is captured into pending and serviced after the following IDLE edge.
- Simultaneous requests: lowest index is served first; the others remain pending and are served in index order.
- epc_out and cause hold their values until the next service; mem_addr holds its last value after FETCH.
- No illegal states: a default branch returns to IDLE with all strobes low.

Test Plan:
- Reset, then exc_req=3'b010 for one cycle with pc_in=0x00000040, MEM_LAT=1, memory byte[254]=0x80:
  - FETCH cycle: mem_addr=254, mem_rd=1, epc_we=1, epc_out=0x3C.
  - Next cycle: pc_we=1, pc_out=0x00000080, cause=1.
  - Next cycle: busy=0.
- exc_req=3'b101 in one cycle, byte[253]=0x10, byte[255]=0x20:
  - First service: cause=0, pc_out=0x10.
  - One IDLE cycle.
  - Second service: cause=2, pc_out=0x20, with no new request needed.
- MEM_LAT=3 build, exc_req=3'b100:
  - mem_rd high for exactly 3 cycles with mem_addr=255.
  - pc_we pulses once, on the 4th cycle after detection.
  - epc_we pulses once.
- pc_in=0x00000000 with any request -> epc_out=0xFFFFFFFC.
- Reset asserted during the FETCH cycle of a service while a second exception is pending:
  - All outputs go to 0 immediately and pending clears.
  - No pc_we pulse appears after reset releases.
- NUM_EXC=5, VEC_BASE=200 build, exc_req=5'b10000 -> mem_addr=204, cause=4 (CW=3).
